// File: rtl/icap_readback_packer.sv
// Reads word_count 32-bit beats from ICAP and packs each 8 beats into one 256-bit FIFO word.
// Define ICAP_READBACK_BITSWAP_EN to bit-reverse every byte of a beat as it is captured.
module icap_readback_packer #(
   parameter int DATA_SIZE      = 256,
   parameter int FLAG_SIZE      = 1,
   parameter int ICAP_DATA_SIZE = 32,
   parameter int COUNT_WIDTH    = 24
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [COUNT_WIDTH-1:0]    word_count,
   input  logic                      abort,
   input  logic [ICAP_DATA_SIZE-1:0] icap_data_in,
   input  logic                      icap_busy,
   output logic [FLAG_SIZE-1:0]      icap_en,
   output logic                      icap_rdwrb,
   input  logic [FLAG_SIZE-1:0]      fifo_full,
   output logic [FLAG_SIZE-1:0]      fifo_wr_en,
   output logic [DATA_SIZE-1:0]      fifo_data,
   output logic                      busy,
   output logic                      done
);
   localparam int SLOTS  = DATA_SIZE / ICAP_DATA_SIZE;
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      READ_ICAP,
      WRITE_FIFO,
      FINISH
   } state_t;

   state_t                    state;
   logic [COUNT_WIDTH-1:0]    remaining;
   logic [SLOT_W-1:0]         slot;
   logic [DATA_SIZE-1:0]      pack;
   logic [ICAP_DATA_SIZE-1:0] beat;
   logic                      last_beat;
   logic                      write_now;

   always_comb begin
      beat = icap_data_in;
`ifdef ICAP_READBACK_BITSWAP_EN
      for (int unsigned b = 0; b < ICAP_DATA_SIZE / 8; b++) begin
         for (int unsigned i = 0; i < 8; i++) begin
            beat[b*8 + i] = icap_data_in[b*8 + 7 - i];
         end
      end
`endif
   end

   // A word closes on its eighth slot or on the final requested beat; unfilled slots stay zero.
   assign last_beat = (slot == SLOT_W'(SLOTS - 1)) || (remaining == COUNT_WIDTH'(1));

   // Write strobe is combinational so a stalled FIFO is written in the first cycle it frees up.
   assign write_now  = (state == WRITE_FIFO) && !fifo_full[0] && !abort;
   assign fifo_wr_en = write_now ? '0 : '1;
   assign fifo_data  = pack;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         remaining  <= '0;
         slot       <= '0;
         pack       <= '0;
         icap_en    <= '1;
         icap_rdwrb <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && (state inside {SETUP, READ_ICAP, WRITE_FIFO})) begin
            state   <= FINISH;
            icap_en <= '1;
            done    <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     busy       <= 1'b1;
                     icap_rdwrb <= 1'b1;
                     if (word_count != '0) begin
                        remaining <= word_count;
                        slot      <= '0;
                        pack      <= '0;
                        state     <= SETUP;
                     end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                     end
                  end
               end
               SETUP: begin
                  state   <= READ_ICAP;
                  icap_en <= '0;
               end
               READ_ICAP: begin
                  if (!icap_busy) begin
                     pack[32'(slot)*ICAP_DATA_SIZE +: ICAP_DATA_SIZE] <= beat;
                     slot      <= slot + SLOT_W'(1);
                     remaining <= remaining - COUNT_WIDTH'(1);
                     if (last_beat) begin
                        state   <= WRITE_FIFO;
                        icap_en <= '1;
                     end
                  end
               end
               WRITE_FIFO: begin
                  if (write_now) begin
                     if (remaining != '0) begin
                        pack    <= '0;
                        slot    <= '0;
                        state   <= READ_ICAP;
                        icap_en <= '0;
                     end else begin
                        state <= FINISH;
                        done  <= 1'b1;
                     end
                  end
               end
               FINISH: begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  icap_rdwrb <= 1'b0;
               end
               default: begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  icap_rdwrb <= 1'b0;
                  icap_en    <= '1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_icap_readback_packer.sv
// Bench for icap_readback_packer: directed table of transfers, reset corner cases and random transfers
// checked against a packing model; honours ICAP_READBACK_BITSWAP_EN like the design.
module tb_icap_readback_packer;
   localparam int CW = 24;

   logic          clock = 1'b0;
   logic          reset, start, abort, icap_busy;
   logic [CW-1:0] word_count;
   logic [31:0]   icap_data_in;
   logic [0:0]    icap_en, fifo_full, fifo_wr_en;
   logic          icap_rdwrb, busy, done;
   logic [255:0]  fifo_data;
   logic [255:0]  last_word;
   int            compared   = 0;
   int            mismatched = 0;

   typedef struct {
      int n;
      int busy_pct;
      int full_hold;
      int abort_at;
      bit spam;
      int exp_beats;
      int exp_writes;
   } vec_t;

   vec_t vecs[10];

   icap_readback_packer #(
      .DATA_SIZE(256),
      .FLAG_SIZE(1),
      .ICAP_DATA_SIZE(32),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .word_count(word_count),
      .abort(abort),
      .icap_data_in(icap_data_in),
      .icap_busy(icap_busy),
      .icap_en(icap_en),
      .icap_rdwrb(icap_rdwrb),
      .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en),
      .fifo_data(fifo_data),
      .busy(busy),
      .done(done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] swap_bytes(input logic [31:0] v);
`ifdef ICAP_READBACK_BITSWAP_EN
      logic [7:0]  b;
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         b = v[k*8 +: 8];
         r[k*8 +: 8] = {<<{b}};
      end
      return r;
`else
      return v;
`endif
   endfunction

   function automatic logic [31:0] beat_val(input int i, input int mode, input logic [31:0] seed);
      case (mode)
         0:       return 32'(i + 1);
         1:       return (seed ^ (32'(i) * 32'h9E3779B9)) + 32'(i);
         default: return 32'h01020304;
      endcase
   endfunction

   // Word j of a transfer: beats 8j..8j+7, first beat lowest, zero beyond the last beat.
   function automatic logic [255:0] exp_word(input int j, input int n, input int mode, input logic [31:0] seed);
      logic [255:0] w = '0;
      for (int s = 0; s < 8; s++) begin
         if (8*j + s < n) w[s*32 +: 32] = swap_bytes(beat_val(8*j + s, mode, seed));
      end
      return w;
   endfunction

   task automatic xfer(input string tag, input int n, input int busy_pct, input int full_hold,
                       input int full_pct, input int abort_at, input bit spam, input int mode,
                       input int exp_beats, input int exp_writes);
      logic [31:0] seed = $urandom;
      int acc = 0, act_writes = 0, writes = 0, cyc = 0, stall = 0;
      int first_en = -1, last_wr = -1, done_cyc = -1, abort_cyc = -1;
      bit pending = 0, exp_wr = 0;
      bit abort_next = (abort_at == 0);
      @(negedge clock);
      start = 1'b1; word_count = CW'(n); abort = 1'b0; icap_busy = 1'b0; fifo_full = 1'b0;
      while (done_cyc < 0 && cyc < 400) begin
         @(negedge clock);
         cyc++;
         start      = spam ? 1'($urandom_range(1)) : 1'b0;
         word_count = spam ? CW'($urandom) : CW'(n);
         abort      = abort_next;
         if (abort_next) begin
            abort_next = 0;
            abort_cyc  = cyc;
         end
         icap_busy    = (busy_pct < 0) ? 1'(cyc % 2) : 1'($urandom_range(99) < busy_pct);
         icap_data_in = (acc < n) ? beat_val(acc, mode, seed) : $urandom;
         if (pending && stall < full_hold) begin
            fifo_full = 1'b1;
            stall++;
         end else begin
            fifo_full = 1'($urandom_range(99) < full_pct);
         end
         #1;
         if (cyc == 1 && n > 0) begin
            check({tag, ":setup_rdwrb"}, icap_rdwrb, 1'b1);
            check({tag, ":setup_en"}, icap_en, 1'b1);
         end
         exp_wr = pending && !fifo_full[0] && !abort;
         check({tag, ":wr_en"}, fifo_wr_en, !exp_wr);
         if (pending) check({tag, ":en_during_write"}, icap_en, 1'b1);
         if (fifo_wr_en == 1'b0) act_writes++;
         if (exp_wr) begin
            check({tag, ":fifo_data"}, fifo_data, exp_word(writes, n, mode, seed));
            last_word = fifo_data;
            writes++;
            last_wr = cyc;
            pending = 0;
            stall   = 0;
         end
         if (abort) pending = 0;
         if (icap_en == 1'b0) begin
            if (first_en < 0) first_en = cyc;
            check({tag, ":rdwrb_while_en"}, icap_rdwrb, 1'b1);
            if (!icap_busy && !abort) begin
               acc++;
               if (acc % 8 == 0 || acc == n) pending = 1;
               if (acc == abort_at) abort_next = 1;
            end
         end
         if (done) begin
            done_cyc = cyc;
            check({tag, ":busy_at_done"}, busy, 1'b1);
            check({tag, ":en_at_done"}, icap_en, 1'b1);
         end
      end
      check({tag, ":done_seen"}, done_cyc > 0, 1'b1);
      check({tag, ":beats"}, acc, exp_beats);
      check({tag, ":writes"}, act_writes, exp_writes);
      if (abort_cyc > 0) begin
         check({tag, ":abort_to_done"}, done_cyc, abort_cyc + 1);
      end else if (n > 0) begin
         check({tag, ":start_to_en"}, first_en, 2);
         check({tag, ":write_to_done"}, done_cyc, last_wr + 1);
      end else begin
         check({tag, ":zero_done"}, done_cyc, 1);
         check({tag, ":zero_no_read"}, first_en, -1);
      end
      @(negedge clock);
      start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
      #1;
      check({tag, ":idle_busy"}, busy, 1'b0);
      check({tag, ":idle_done"}, done, 1'b0);
      check({tag, ":idle_rdwrb"}, icap_rdwrb, 1'b0);
      check({tag, ":idle_en"}, icap_en, 1'b1);
   endtask

   initial begin
      int n, ab, eb, ew;
      reset = 1'b0; start = 1'b0; abort = 1'b0; icap_busy = 1'b0; fifo_full = 1'b0;
      word_count = '0; icap_data_in = '0; last_word = '0;
      vecs[0] = '{8, 0, 0, -1, 0, 8, 1};
      vecs[1] = '{11, 0, 0, -1, 0, 11, 2};
      vecs[2] = '{16, -1, 0, -1, 0, 16, 2};
      vecs[3] = '{8, 0, 5, -1, 0, 8, 1};
      vecs[4] = '{20, 0, 0, 12, 1, 12, 1};
      vecs[5] = '{0, 0, 0, -1, 1, 0, 0};
      vecs[6] = '{24, 30, 2, -1, 1, 24, 3};
      vecs[7] = '{20, 0, 0, 8, 0, 8, 0};
      vecs[8] = '{5, 0, 0, 0, 0, 0, 0};
      vecs[9] = '{9, 20, 0, -1, 0, 9, 2};

      #12;
      check("rst_en", icap_en, 1'b1);
      check("rst_rdwrb", icap_rdwrb, 1'b0);
      check("rst_wr_en", fifo_wr_en, 1'b1);
      check("rst_data", fifo_data, '0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clock);
      reset = 1'b1;

      // Reset in the middle of reading: outputs drop back without waiting for a clock.
      @(negedge clock);
      start = 1'b1; word_count = CW'(20); icap_data_in = 32'hDEADBEEF;
      repeat (5) begin
         @(negedge clock);
         start = 1'b0;
      end
      #1;
      check("mid_read_en_low", icap_en, 1'b0);
      reset = 1'b0;
      #1;
      check("mid_read_rst_en", icap_en, 1'b1);
      check("mid_read_rst_wr_en", fifo_wr_en, 1'b1);
      check("mid_read_rst_busy", busy, 1'b0);
      check("mid_read_rst_data", fifo_data, '0);
      @(negedge clock);
      reset = 1'b1;

      // Reset while a write strobe is being driven.
      @(negedge clock);
      start = 1'b1; word_count = CW'(8); fifo_full = 1'b1;
      repeat (11) begin
         @(negedge clock);
         start = 1'b0;
      end
      @(negedge clock);
      fifo_full = 1'b0;
      #1;
      check("mid_write_wr_en_low", fifo_wr_en, 1'b0);
      reset = 1'b0;
      #1;
      check("mid_write_rst_wr_en", fifo_wr_en, 1'b1);
      check("mid_write_rst_rdwrb", icap_rdwrb, 1'b0);
      @(negedge clock);
      reset = 1'b1;

      for (int v = 0; v < 10; v++) begin
         xfer($sformatf("vec%0d", v), vecs[v].n, vecs[v].busy_pct, vecs[v].full_hold, 0,
              vecs[v].abort_at, vecs[v].spam, 0, vecs[v].exp_beats, vecs[v].exp_writes);
      end

`ifndef ICAP_READBACK_BITSWAP_EN
      xfer("ordered8", 8, 0, 0, 0, -1, 0, 0, 8, 1);
      check("ordered8_word", last_word,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
`endif
      xfer("bitorder", 1, 0, 0, 0, -1, 0, 2, 1, 1);
`ifdef ICAP_READBACK_BITSWAP_EN
      check("bitorder_word", last_word, 256'h8040C020);
`else
      check("bitorder_word", last_word, 256'h01020304);
`endif

      // Largest count must keep reading rather than wrap to an early finish.
      xfer("maxcount", 32'h00FFFFFF, 0, 0, 0, 20, 0, 1, 20, 2);

      for (int r = 0; r < 12; r++) begin
         n  = int'($urandom_range(40, 1));
         ab = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
         eb = (ab >= 0) ? ab : n;
         ew = (ab < 0) ? (n + 7) / 8 : ((ab == 0) ? 0 : (ab - 1) / 8);
         xfer($sformatf("rand%0d", r), n, 40, 0, 30, ab, 1'($urandom_range(1)), 1, eb, ew);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/icap_readback_packer.md
Name: icap_readback_packer

Overview:
- Readback-direction partner of the ICAP configuration write path.
- Issues an ICAP read of a requested number of 32-bit words and packs every 8 consecutive words into one 256-bit word.
- Writes packed words into a 256-bit FIFO toward the host side.
- Word order mirrors the write path: first word read lands in bits [31:0], eighth in [255:224].

Parameters:
- DATA_SIZE, 256, FIFO word width; must equal 8*ICAP_DATA_SIZE.
- FLAG_SIZE, 1, width of single-bit flags/enables.
- ICAP_DATA_SIZE, 32, ICAP data port width.
- COUNT_WIDTH, 24, width of requested word count.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- word_count  in  COUNT_WIDTH  number of 32-bit words to read; sampled with start.
- abort  in  1  terminate transfer; sampled every cycle.
- icap_data_in  in  ICAP_DATA_SIZE  ICAP readback data (O port).
- icap_busy  in  1  high = icap_data_in not valid this cycle.
- icap_en  out  FLAG_SIZE  ICAP chip select, active-low (0 = ENABLE, 1 = DISABLE).
- icap_rdwrb  out  1  1 = read, 0 = write.
- fifo_full  in  FLAG_SIZE  FIFO cannot accept a word.
- fifo_wr_en  out  FLAG_SIZE  FIFO write strobe, active-low.
- fifo_data  out  DATA_SIZE  packed word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of a transfer (normal or aborted).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; icap_en=1; icap_rdwrb=0; fifo_wr_en=1; fifo_data=0; done=0; busy=0.
  - Remaining-word counter and slot counter cleared.
  - Applies immediately mid-transfer; the partial word is discarded.
- States: IDLE, SETUP, READ_ICAP, WRITE_FIFO, FINISH.
- IDLE:
  - icap_en=1, icap_rdwrb=0.
  - start=1 and word_count!=0 -> latch count, slot=0, clear pack register -> SETUP.
  - start=1 and word_count==0 -> FINISH; no ICAP or FIFO activity.
- SETUP (exactly 1 cycle): icap_rdwrb=1, icap_en=1. RDWRB never changes while icap_en=0. -> READ_ICAP.
- READ_ICAP:
  - icap_en=0, icap_rdwrb=1.
  - Beat accepted on a rising edge where icap_en=0 and icap_busy=0. Pack register slot[slot] <= icap_data_in; slot++; remaining--.
  - On accepted beat with slot==7 or remaining==1 -> WRITE_FIFO. Unfilled slots stay 0 (zero padding of the final partial word).
  - icap_busy=1 holds the state with no capture.
- WRITE_FIFO:
  - icap_en=1, icap_rdwrb=1.
  - fifo_data holds the packed word for the whole state.
  - fifo_wr_en=0 combinationally when fifo_full=0, for exactly one cycle; otherwise waits with fifo_wr_en=1.
  - After the write: remaining!=0 -> clear pack register, slot=0 -> READ_ICAP; remaining==0 -> FINISH.
- FINISH (1 cycle): icap_en=1, icap_rdwrb=1, done=1 -> IDLE, where icap_rdwrb returns to 0.
- abort=1 in SETUP, READ_ICAP or WRITE_FIFO:
  - Next cycle FINISH; icap_en=1 from that cycle.
  - No FIFO write is issued for the partial word, including a pending write in WRITE_FIFO.
  - abort has priority over beat acceptance in the same cycle.
- start while busy=1 is ignored.
- Latency:
  - start edge -> first icap_en=0 is 2 cycles.
  - 8th accepted beat -> earliest fifo_wr_en=0 is the next cycle.
  - Last write -> done is the next cycle.
- Counter arithmetic is unsigned, COUNT_WIDTH bits. word_count up to 2^COUNT_WIDTH-1 must not wrap.
- Exactly word_count beats are accepted and ceil(word_count/8) FIFO writes are issued per non-aborted transfer.

Optional Feature:
- Macro: ICAP_READBACK_BITSWAP_EN.
- Defined: each captured 32-bit beat is bit-reversed within every byte (bit i of byte b <- bit 7-i of byte b) before packing, matching ICAP's native bit ordering.
- Not defined: beats are packed unmodified.
- Swap is combinational on capture and adds no latency.

Test Plan:
- word_count=8, icap_busy=0, beats 0x00000001..0x00000008 -> one write, fifo_data=0x00000008_..._00000001; done 1 cycle after the write; icap_en low for exactly 8 edges.
- word_count=11, busy=0 -> two writes; second fifo_data[95:0]=beats 9..11 and [255:96]=0; done asserted once.
- word_count=16 with icap_busy high every other cycle -> exactly 16 captures, no duplicated/skipped beat, two correct writes.
- word_count=8, fifo_full held high 5 cycles after packing -> fifo_wr_en stays 1 for those cycles, then pulses 0 once; icap_en stays 1 throughout the stall.
- word_count=20, abort asserted after beat 12 -> one FIFO write only, icap_en=1 next cycle, done pulse, return to IDLE; start during the transfer ignored; word_count=0 start -> done only.
- Reset deasserted/asserted mid-READ_ICAP -> icap_en=1 and fifo_wr_en=1 immediately. With ICAP_READBACK_BITSWAP_EN defined, beat 0x01020304 is packed as 0x8040C020.
